// File: rtl/jk_cmd_seq_if.sv
// Command / excitation bus for jk_cmd_seq.
// master: command source that also observes the JK excitation.
// slave : the sequencer itself.
interface jk_cmd_seq_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [WIDTH-1:0] cmd_data;
  logic [3:0]       cmd_cnt;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             jk_valid;

  modport master (
    output cmd_valid, cmd_op, cmd_mask, cmd_data, cmd_cnt,
    input  cmd_ready, j, k, jk_valid
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mask, cmd_data, cmd_cnt,
    output cmd_ready, j, k, jk_valid
  );
endinterface

// File: rtl/jk_cmd_seq.sv
// jk_cmd_seq: queues JK commands in a small FIFO and issues them as
// registered j/k excitation to a downstream bank of WIDTH JK flops,
// keeping a shadow copy of the bank state.
// Optional macro JK_CMD_SEQ_CHECK_EN adds q_fb/err feedback checking.
//
// state  | meaning
// IDLE   | nothing issued this cycle, j=k=0
// ISSUE  | a popped command drives j/k for this cycle
// REPEAT | a TOGGLE holds j/k; rem_q further cycles still to go
module jk_cmd_seq #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  jk_cmd_seq_if.slave      bus,
  output logic             busy,
  output logic [WIDTH-1:0] shadow_q
`ifdef JK_CMD_SEQ_CHECK_EN
  ,
  input  logic [WIDTH-1:0] q_fb,
  output logic             err
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [2:0] OP_SET    = 3'd1;
  localparam logic [2:0] OP_CLEAR  = 3'd2;
  localparam logic [2:0] OP_TOGGLE = 3'd3;
  localparam logic [2:0] OP_LOAD   = 3'd4;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] data;
    logic [3:0]       cnt;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_REPEAT
  } state_t;

  cmd_t             mem_q [DEPTH];
  cmd_t             mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_en_q, ready_en_d;
  state_t           state_q, state_d;
  logic [3:0]       rem_q, rem_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             jk_valid_q, jk_valid_d;
  logic [WIDTH-1:0] shadow_d;
  logic             cmd_ready_w;
  logic             push;
  logic             pop;
  cmd_t             head;

  // ready comes from registered occupancy only, so a full FIFO refuses a
  // push even on a cycle where it also pops
  assign cmd_ready_w   = ready_en_q && (count_q != CW'(DEPTH));
  assign push          = bus.cmd_valid && cmd_ready_w;
  assign head          = mem_q[rd_ptr_q];
  assign bus.cmd_ready = cmd_ready_w;
  assign bus.j         = j_q;
  assign bus.k         = k_q;
  assign bus.jk_valid  = jk_valid_q;
  assign busy          = (count_q != '0) || (state_q != ST_IDLE);

  // FIFO write, pointer and occupancy update
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ready_en_d = 1'b1;
    if (push) begin
      mem_d[wr_ptr_q] = '{op: bus.cmd_op, mask: bus.cmd_mask,
                          data: bus.cmd_data, cnt: bus.cmd_cnt};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // issue FSM: pop/decode the head command or repeat a TOGGLE
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    j_d        = '0;
    k_d        = '0;
    jk_valid_d = 1'b0;
    pop        = 1'b0;
    if (state_q == ST_REPEAT && rem_q != 4'd0) begin
      j_d        = j_q;
      k_d        = k_q;
      jk_valid_d = 1'b1;
      rem_d      = rem_q - 4'd1;
    end else if (count_q != '0) begin
      pop        = 1'b1;
      jk_valid_d = 1'b1;
      state_d    = ST_ISSUE;
      rem_d      = 4'd0;
      case (head.op)
        OP_SET:   j_d = head.mask;
        OP_CLEAR: k_d = head.mask;
        OP_TOGGLE: begin
          j_d = head.mask;
          k_d = head.mask;
          // cnt of 0 or 1 means a single cycle; otherwise stay for cnt-1 more
          if (head.cnt > 4'd1) begin
            state_d = ST_REPEAT;
            rem_d   = head.cnt - 4'd1;
          end
        end
        OP_LOAD: begin
          j_d = head.mask & head.data & ~shadow_q;
          k_d = head.mask & ~head.data & shadow_q;
        end
        default: ;
      endcase
    end else begin
      state_d = ST_IDLE;
    end
  end

  // shadow follows the downstream bank one edge after each valid cycle
  always_comb begin
    shadow_d = shadow_q;
    if (jk_valid_q) begin
      shadow_d = (j_q & ~shadow_q) | (~k_q & shadow_q);
    end
  end

  // FIFO storage needs no reset; pointers and count define validity
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // control state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
      state_q    <= ST_IDLE;
      rem_q      <= 4'd0;
      j_q        <= '0;
      k_q        <= '0;
      jk_valid_q <= 1'b0;
      shadow_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_en_q <= ready_en_d;
      state_q    <= state_d;
      rem_q      <= rem_d;
      j_q        <= j_d;
      k_q        <= k_d;
      jk_valid_q <= jk_valid_d;
      shadow_q   <= shadow_d;
    end
  end

`ifdef JK_CMD_SEQ_CHECK_EN
  logic err_q, err_d;

  // sticky mismatch flag between real flop outputs and the shadow model
  always_comb begin
    err_d = err_q;
    if ((q_fb != shadow_q) && ((state_q != ST_IDLE) || busy)) begin
      err_d = 1'b1;
    end
  end

  // error flag register, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule
